// File: rtl/arbiter_pkg.sv
// ============================================================================
//  Module      : arbiter_pkg
//  Description : Shared types and helpers for the request arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arbiter_pkg;

    typedef enum logic [1:0] {
        HOLD_NONE = 2'd0,
        HOLD_REQ  = 2'd1,
        HOLD_ACK  = 2'd2
    } hold_mode_e;

    // Collapses the two blocking parameters into a single release policy.
    function automatic hold_mode_e hold_mode(input int arb_block, input int arb_block_ack);
        if (arb_block == 0) begin
            return HOLD_NONE;
        end
        return (arb_block_ack != 0) ? HOLD_ACK : HOLD_REQ;
    endfunction

endpackage

`default_nettype wire

// File: rtl/priority_encoder.sv
// ============================================================================
//  Module      : priority_encoder
//  Description : Picks the highest (or lowest) set bit; binary and one-hot out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module priority_encoder #(
    parameter int WIDTH             = 4,
    parameter int LSB_HIGH_PRIORITY = 0
) (
    input  logic [WIDTH-1:0]         unencoded,
    output logic                     valid,
    output logic [$clog2(WIDTH)-1:0] encoded,
    output logic [WIDTH-1:0]         onehot
);

    localparam int c_IDX_W = $clog2(WIDTH);

    // Later hits overwrite earlier ones, so scan order sets the priority.
    always_comb begin
        valid   = |unencoded;
        encoded = '0;
        onehot  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            int j;
            j = (LSB_HIGH_PRIORITY != 0) ? (WIDTH - 1 - i) : i;
            if (unencoded[j]) begin
                encoded   = c_IDX_W'(j);
                onehot    = '0;
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/arbiter.sv
// ============================================================================
//  Module      : arbiter
//  Description : Fixed-priority / round-robin arbiter with optional grant hold.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbiter
    import arbiter_pkg::*;
#(
    parameter int PORTS                 = 4,
    parameter int ARB_TYPE_ROUND_ROBIN  = 0,
    parameter int ARB_BLOCK             = 0,
    parameter int ARB_BLOCK_ACK         = 1,
    parameter int ARB_LSB_HIGH_PRIORITY = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PORTS-1:0]         request,
    input  logic [PORTS-1:0]         acknowledge,
    output logic [PORTS-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(PORTS)-1:0] grant_encoded
);

    localparam int               c_IDX_W     = $clog2(PORTS);
    localparam logic [PORTS-1:0] c_ONE       = PORTS'(1);
    localparam hold_mode_e       c_HOLD_MODE = hold_mode(ARB_BLOCK, ARB_BLOCK_ACK);

    logic [PORTS-1:0]   r_grant;
    logic               r_grant_valid;
    logic [c_IDX_W-1:0] r_grant_encoded;
    logic [PORTS-1:0]   r_mask;

    logic               w_req_valid;
    logic [c_IDX_W-1:0] w_req_idx;
    logic [PORTS-1:0]   w_req_oh;
    logic               w_mreq_valid;
    logic [c_IDX_W-1:0] w_mreq_idx;
    logic [PORTS-1:0]   w_mreq_oh;
    logic               w_sel_valid;
    logic [c_IDX_W-1:0] w_sel_idx;
    logic [PORTS-1:0]   w_sel_oh;
    logic [PORTS-1:0]   w_mask_next;
    logic               w_hold;

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
    ) u_enc_req (
        .unencoded (request),
        .valid     (w_req_valid),
        .encoded   (w_req_idx),
        .onehot    (w_req_oh)
    );

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
    ) u_enc_masked (
        .unencoded (request & r_mask),
        .valid     (w_mreq_valid),
        .encoded   (w_mreq_idx),
        .onehot    (w_mreq_oh)
    );

    generate
        case (c_HOLD_MODE)
            HOLD_ACK: begin : g_hold_ack
                assign w_hold = r_grant_valid && ((r_grant & acknowledge) == '0);
            end
            HOLD_REQ: begin : g_hold_req
                logic w_ack_unused;
                assign w_ack_unused = ^acknowledge;
                assign w_hold       = (r_grant & request) != '0;
            end
            default: begin : g_hold_none
                logic w_ack_unused;
                assign w_ack_unused = ^acknowledge;
                assign w_hold       = 1'b0;
            end
        endcase
    endgenerate

    // A masked hit continues the rotation; otherwise wrap to the plain winner.
    always_comb begin
        w_sel_valid = w_req_valid;
        w_sel_idx   = w_req_idx;
        w_sel_oh    = w_req_oh;
        if ((ARB_TYPE_ROUND_ROBIN != 0) && w_mreq_valid) begin
            w_sel_idx = w_mreq_idx;
            w_sel_oh  = w_mreq_oh;
        end
    end

    // Next mask admits only ports ranked below the new winner.
    always_comb begin
        w_mask_next = '0;
        if (ARB_LSB_HIGH_PRIORITY != 0) begin
            w_mask_next = ~(w_sel_oh | (w_sel_oh - c_ONE));
        end else begin
            w_mask_next = w_sel_oh - c_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant         <= '0;
            r_grant_valid   <= 1'b0;
            r_grant_encoded <= '0;
            r_mask          <= '0;
        end else if (!w_hold) begin
            r_grant         <= w_sel_valid ? w_sel_oh : '0;
            r_grant_valid   <= w_sel_valid;
            r_grant_encoded <= w_sel_valid ? w_sel_idx : '0;
            if (w_sel_valid && (ARB_TYPE_ROUND_ROBIN != 0)) begin
                r_mask <= w_mask_next;
            end
        end
    end

    assign grant         = r_grant;
    assign grant_valid   = r_grant_valid;
    assign grant_encoded = r_grant_encoded;

endmodule

`default_nettype wire

// File: tb/tb_arbiter.sv
// ============================================================================
//  Module      : tb_arbiter
//  Description : Directed plus randomized check of three arbiter configurations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] req_rr, ack_rr, grant_rr;
    logic        gv_rr;
    logic [4:0]  ge_rr;
    logic [7:0]  req_fm, ack_fm, grant_fm;
    logic        gv_fm;
    logic [2:0]  ge_fm;
    logic [7:0]  req_fl, ack_fl, grant_fl;
    logic        gv_fl;
    logic [2:0]  ge_fl;

    arbiter #(.PORTS(32), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0),
              .ARB_LSB_HIGH_PRIORITY(0)) dut_rr (
        .clk(clk), .rst(rst), .request(req_rr), .acknowledge(ack_rr),
        .grant(grant_rr), .grant_valid(gv_rr), .grant_encoded(ge_rr));

    arbiter #(.PORTS(8), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0),
              .ARB_LSB_HIGH_PRIORITY(0)) dut_fm (
        .clk(clk), .rst(rst), .request(req_fm), .acknowledge(ack_fm),
        .grant(grant_fm), .grant_valid(gv_fm), .grant_encoded(ge_fm));

    arbiter #(.PORTS(8), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1),
              .ARB_LSB_HIGH_PRIORITY(1)) dut_fl (
        .clk(clk), .rst(rst), .request(req_fl), .acknowledge(ack_fl),
        .grant(grant_fl), .grant_valid(gv_fl), .grant_encoded(ge_fl));

    // Model state: granted port (-1 when idle) and the last new winner.
    typedef struct packed {
        int   g;
        int   last;
        logic have_last;
    } mstate_t;

    mstate_t m_rr, m_fm, m_fl;
    int n_cmp  = 0;
    int n_fail = 0;

    function automatic mstate_t reset_state();
        mstate_t s;
        s.g         = -1;
        s.last      = 0;
        s.have_last = 1'b0;
        return s;
    endfunction

    function automatic int pick(input logic [31:0] set, input bit lsb);
        int r;
        r = -1;
        for (int i = 0; i < 32; i++) begin
            if (set[i] && (!lsb || r < 0)) r = i;
        end
        return r;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic [31:0] req,
                                           input logic [31:0] ack, input bit rr,
                                           input bit blk, input bit ackm, input bit lsb);
        mstate_t     n;
        logic [31:0] eligible;
        int          p;
        n        = s;
        eligible = '0;
        if (blk && s.g >= 0) begin
            if (ackm ? !ack[s.g] : req[s.g]) return n;
        end
        if (rr && s.have_last) begin
            for (int i = 0; i < 32; i++) begin
                eligible[i] = lsb ? (i > s.last) : (i < s.last);
            end
        end
        p = pick(req & eligible, lsb);
        if (p < 0) p = pick(req, lsb);
        n.g = p;
        if (p >= 0) begin
            n.last      = p;
            n.have_last = 1'b1;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input string name, input mstate_t s, input logic [31:0] g,
                              input logic v, input logic [31:0] e);
        check({name, ".grant"}, g, (s.g >= 0) ? (32'd1 << s.g) : 32'd0);
        check({name, ".valid"}, {31'd0, v}, {31'd0, (s.g >= 0)});
        check({name, ".encoded"}, e, (s.g >= 0) ? 32'(s.g) : 32'd0);
    endtask

    task automatic check_all();
        check_inst("rr", m_rr, grant_rr, gv_rr, {27'd0, ge_rr});
        check_inst("fm", m_fm, {24'd0, grant_fm}, gv_fm, {29'd0, ge_fm});
        check_inst("fl", m_fl, {24'd0, grant_fl}, gv_fl, {29'd0, ge_fl});
    endtask

    task automatic step();
        @(posedge clk);
        m_rr = model_next(m_rr, req_rr, ack_rr, 1'b1, 1'b1, 1'b0, 1'b0);
        m_fm = model_next(m_fm, {24'd0, req_fm}, {24'd0, ack_fm}, 1'b0, 1'b1, 1'b0, 1'b0);
        m_fl = model_next(m_fl, {24'd0, req_fl}, {24'd0, ack_fl}, 1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        check_all();
    endtask

    task automatic reset_models();
        m_rr = reset_state();
        m_fm = reset_state();
        m_fl = reset_state();
    endtask

    initial begin
        rst    = 1'b0;
        req_rr = '0; ack_rr = '0;
        req_fm = '0; ack_fm = '0;
        req_fl = '0; ack_fl = '0;
        reset_models();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;

        req_rr = 32'd1 << 5;
        step();
        check("single.grant", grant_rr, 32'h0000_0020);
        check("single.encoded", {27'd0, ge_rr}, 32'd5);

        req_rr = (32'd1 << 5) | (32'd1 << 10);
        step();
        check("block.hold", grant_rr, 32'd1 << 5);
        req_rr = 32'd1 << 10;
        step();
        check("block.move", grant_rr, 32'd1 << 10);

        req_rr = '0;
        step();
        check("idle.valid", {31'd0, gv_rr}, 32'd0);

        req_rr = (32'd1 << 5) | (32'd1 << 10) | (32'd1 << 20);
        step();
        check("rr.rotate", grant_rr, 32'd1 << 5);
        req_rr = (32'd1 << 10) | (32'd1 << 20);
        step();
        check("rr.wrap", grant_rr, 32'd1 << 20);

        req_rr = '0;
        step();
        req_rr = 32'd1 << 7;
        step();
        check("pre_reset.grant", grant_rr, 32'd1 << 7);

        rst = 1'b0;
        reset_models();
        #1;
        check_all();
        check("async_reset.grant", grant_rr, 32'd0);
        #2 rst = 1'b1;

        req_rr = (32'd1 << 3) | (32'd1 << 7);
        req_fm = 8'h88;
        req_fl = 8'h88;
        step();
        check("post_reset.grant", grant_rr, 32'd1 << 7);
        check("fixed_msb.grant", {24'd0, grant_fm}, 32'h80);
        check("fixed_lsb.grant", {24'd0, grant_fl}, 32'h08);

        // Acknowledge mode: dropping the request alone keeps the grant.
        req_fl = 8'h00;
        step();
        check("ack.hold", {24'd0, grant_fl}, 32'h08);
        req_fl = 8'h80;
        ack_fl = 8'h08;
        step();
        check("ack.release", {24'd0, grant_fl}, 32'h80);

        for (int it = 0; it < 600; it++) begin
            req_rr = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom & $urandom & $urandom);
            ack_rr = $urandom;
            req_fm = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom & $urandom);
            ack_fm = 8'($urandom);
            req_fl = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom & $urandom);
            ack_fl = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'd0;
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b0;
                reset_models();
                #1;
                check_all();
                #2 rst = 1'b1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/arbiter.md
ARBITER -- requirements
Module: arbiter

Interface
REQ-001 Parameter PORTS, default 4: number of requesters, minimum 2.
REQ-002 Parameter ARB_TYPE_ROUND_ROBIN, default 0: 1 = round-robin, 0 = fixed priority.
REQ-003 Parameter ARB_BLOCK, default 0: 1 = hold the current grant (blocking mode).
REQ-004 Parameter ARB_BLOCK_ACK, default 1: in blocking mode, 1 = release on acknowledge, 0 = release on request deassert.
REQ-005 Parameter ARB_LSB_HIGH_PRIORITY, default 0: 1 = lowest index wins, 0 = highest index wins.
REQ-006 Port clk, input, 1 bit: single clock, rising edge.
REQ-007 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-008 Port request, input, PORTS bits: per-port request.
REQ-009 Port acknowledge, input, PORTS bits: per-port release, used only when ARB_BLOCK=1 and ARB_BLOCK_ACK=1.
REQ-010 Port grant, output, PORTS bits: registered one-hot grant, or all zeros.
REQ-011 Port grant_valid, output, 1 bit: high when grant is nonzero.
REQ-012 Port grant_encoded, output, $clog2(PORTS) bits: binary index of the granted port; 0 when grant_valid=0.

Function
REQ-013 All outputs SHALL be registered, with a latency of one clock from request to grant.
REQ-014 Hold rule, ARB_BLOCK=1 and ARB_BLOCK_ACK=0: while (grant & request) is nonzero, grant, grant_valid and grant_encoded SHALL keep their values.
REQ-015 Hold rule, ARB_BLOCK=1 and ARB_BLOCK_ACK=1: while grant_valid=1 and (grant & acknowledge) is zero, the outputs SHALL keep their values; request deassert alone SHALL NOT release the grant.
REQ-016 When not holding and no request bit is set, the next outputs SHALL be grant=0, grant_valid=0, grant_encoded=0.
REQ-017 Fixed priority: the next grant SHALL go to the highest set request index, or the lowest set index when ARB_LSB_HIGH_PRIORITY=1.
REQ-018 Round-robin: an internal PORTS-bit mask SHALL be kept; when (request & mask) is nonzero, the priority pick SHALL be made over the masked requests, otherwise over all requests.
REQ-019 Round-robin mask update: on each new grant to index i, the mask SHALL be set to the bits below i when ARB_LSB_HIGH_PRIORITY=0, or to the bits above i when it is 1.
REQ-020 Round-robin wrap: when no masked request exists, selection SHALL wrap to the unmasked priority winner.
REQ-021 The mask SHALL change only on a new grant; it SHALL NOT change while a grant is held or while idle.
REQ-022 Non-blocking mode (ARB_BLOCK=0): arbitration SHALL be re-run every cycle.
REQ-023 A grant that is released and re-arbitrated in the same cycle SHALL take effect on the next clock edge, with no idle cycle in between.

Reset
REQ-024 While rst=0, the outputs SHALL be forced asynchronously to grant=0, grant_valid=0, grant_encoded=0, and the mask SHALL be cleared to 0.
REQ-025 After rst returns high, the first arbitration SHALL behave as fixed priority, because the mask is zero.

Structure
REQ-026 A sub-module priority_encoder SHALL be used, with parameters WIDTH and LSB_HIGH_PRIORITY and outputs valid, encoded and one-hot mask; it SHALL be instantiated twice, once for request and once for request & mask.
REQ-027 No shared package is required; widths SHALL be derived locally with $clog2(PORTS).

Verification
All scenarios use PORTS=32, round-robin, ARB_BLOCK=1, ARB_BLOCK_ACK=0, MSB high priority.
REQ-028 Single request: request=1<<5 -> after one clock, grant=1<<5, grant_valid=1, grant_encoded=5.
REQ-029 Blocking: hold request[5] and add request[10] -> grant stays on port 5; drop request[5] -> grant moves to port 10 on the next clock.
REQ-030 Round-robin rotation:
- After port 10 is granted and released, present requests on ports 5, 10 and 20 -> grant goes to port 5.
- Then release port 5, leaving ports 10 and 20 -> grant wraps to port 20.
REQ-031 Idle: request=0 with no grant held -> after one clock, grant=0, grant_valid=0, grant_encoded=0.
REQ-032 Reset mid-grant: assert rst=0 while port 7 is granted -> outputs go to zero immediately; after release, requests on ports 3 and 7 -> port 7 is granted.
REQ-033 Fixed-priority variant (ARB_TYPE_ROUND_ROBIN=0): simultaneous requests on ports 3 and 7 -> port 7 is granted; with ARB_LSB_HIGH_PRIORITY=1 -> port 3 is granted.
